// File: rtl/bit_serial_stack.sv
// bit_serial_stack
// Small operand stack that evaluates binary operations one bit at a time
// through an external 1-bit ALU slice. The two top entries (TOS, NOS) are
// streamed LSB-first to the slice; the serial result replaces NOS and the
// stack shrinks by one.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_kind            : 0=PUSH, 1=POP, 2=EXEC, 3=CLEAR
//   cmd_op, cmd_cin     : ALU select and chain seed captured by EXEC
//   cmd_data            : PUSH operand
//   alu_a/alu_b/alu_c   : serial operand bits and chain bit to the slice
//   alu_s               : ALU select held from the last EXEC
//   alu_out, alu_cout   : slice result bit and chain-out
//   top, count          : top-of-stack value (0 when empty) and occupancy
//   flag                : final chain-out of the last completed EXEC
//   done, err           : one-cycle completion pulse, err marks a rejection
module bit_serial_stack #(
    parameter int WORD  = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_kind,
    input  logic [2:0]      cmd_op,
    input  logic            cmd_cin,
    input  logic [WORD-1:0] cmd_data,
    output logic            alu_a,
    output logic            alu_b,
    output logic            alu_c,
    output logic [2:0]      alu_s,
    input  logic            alu_out,
    input  logic            alu_cout,
    output logic [WORD-1:0] top,
    output logic [CW-1:0]   count,
    output logic            flag,
    output logic            done,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (WORD > 1) ? $clog2(WORD) : 1;

    localparam logic [1:0] K_PUSH  = 2'd0;
    localparam logic [1:0] K_POP   = 2'd1;
    localparam logic [1:0] K_EXEC  = 2'd2;
    localparam logic [1:0] K_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [WORD-1:0] stack_r [DEPTH];
    logic [CW-1:0]   count_r;
    logic            flag_r;
    logic            done_r;
    logic            err_r;
    logic [2:0]      op_r;
    logic            chain_r;
    logic [IW-1:0]   bit_idx_r;
    logic [WORD-1:0] result_r;

    logic            accept_s;
    logic            push_ok_s;
    logic            exec_ok_s;
    logic [AW-1:0]   wr_idx_s;
    logic [AW-1:0]   tos_idx_s;
    logic [AW-1:0]   nos_idx_s;
    logic [WORD-1:0] tos_word_s;
    logic [WORD-1:0] nos_word_s;

    assign accept_s  = cmd_valid && (state_r == S_IDLE);
    assign push_ok_s = accept_s && (cmd_kind == K_PUSH) && (count_r < CW'(DEPTH));
    assign exec_ok_s = accept_s && (cmd_kind == K_EXEC) && (count_r >= CW'(2));

    // Indices are truncated to the array width; they are only used when in range.
    assign wr_idx_s   = AW'(count_r);
    assign tos_idx_s  = AW'(count_r - CW'(1));
    assign nos_idx_s  = AW'(count_r - CW'(2));
    assign tos_word_s = stack_r[tos_idx_s];
    assign nos_word_s = stack_r[nos_idx_s];

    assign cmd_ready = (state_r == S_IDLE);
    assign count     = count_r;
    assign flag      = flag_r;
    assign done      = done_r;
    assign err       = err_r;
    assign alu_s     = op_r;

    // Next-state logic for the IDLE -> SHIFT -> WB sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (exec_ok_s) begin
                    state_s = S_SHIFT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bit_idx_r == IW'(WORD - 1)) begin
                    state_s = S_WB;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_WB:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Serial operand drive; the slice sees zeros whenever no bit is in flight.
    always_comb begin
        alu_a = 1'b0;
        alu_b = 1'b0;
        alu_c = 1'b0;
        if (state_r == S_SHIFT) begin
            alu_a = tos_word_s[bit_idx_r];
            alu_b = nos_word_s[bit_idx_r];
            alu_c = chain_r;
        end else begin
            alu_a = 1'b0;
            alu_b = 1'b0;
            alu_c = 1'b0;
        end
    end

    // Top-of-stack view straight from the registered stack.
    always_comb begin
        if (count_r != {CW{1'b0}}) begin
            top = tos_word_s;
        end else begin
            top = {WORD{1'b0}};
        end
    end

    // Stack storage: written by an accepted PUSH or by the writeback cycle only.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            stack_r[wr_idx_s] <= cmd_data;
        end else if (!rst && (state_r == S_WB)) begin
            stack_r[nos_idx_s] <= result_r;
        end
    end

    // Control and datapath registers: command execution, serial step, writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            count_r   <= {CW{1'b0}};
            flag_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            op_r      <= 3'b000;
            chain_r   <= 1'b0;
            bit_idx_r <= {IW{1'b0}};
            result_r  <= {WORD{1'b0}};
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        case (cmd_kind)
                            K_PUSH: begin
                                done_r <= 1'b1;
                                if (push_ok_s) begin
                                    count_r <= count_r + CW'(1);
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            K_POP: begin
                                done_r <= 1'b1;
                                if (count_r != {CW{1'b0}}) begin
                                    count_r <= count_r - CW'(1);
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            K_EXEC: begin
                                if (exec_ok_s) begin
                                    op_r      <= cmd_op;
                                    chain_r   <= cmd_cin;
                                    bit_idx_r <= {IW{1'b0}};
                                end else begin
                                    done_r <= 1'b1;
                                    err_r  <= 1'b1;
                                end
                            end
                            K_CLEAR: begin
                                done_r  <= 1'b1;
                                count_r <= {CW{1'b0}};
                                flag_r  <= 1'b0;
                            end
                            default: begin
                                done_r <= 1'b0;
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    result_r[bit_idx_r] <= alu_out;
                    chain_r             <= alu_cout;
                    bit_idx_r           <= bit_idx_r + IW'(1);
                    // done is registered, so raise it on the edge that enters WB.
                    if (bit_idx_r == IW'(WORD - 1)) begin
                        done_r <= 1'b1;
                    end
                end
                S_WB: begin
                    count_r <= count_r - CW'(1);
                    flag_r  <= chain_r;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_serial_stack.md
BIT_SERIAL_STACK -- requirements
Module: bit_serial_stack

Interface
REQ-001 SHALL have parameter WORD, default 4, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of stack entries (DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_kind  input  2  0=PUSH, 1=POP, 2=EXEC, 3=CLEAR.
REQ-008 SHALL have port cmd_op  input  3  ALU select forwarded for EXEC.
REQ-009 SHALL have port cmd_cin  input  1  chain seed for bit 0 of EXEC.
REQ-010 SHALL have port cmd_data  input  WORD  PUSH operand.
REQ-011 SHALL have ports alu_a, alu_b, alu_c  output  1 each  serial operand bits and chain bit to the 1-bit ALU.
REQ-012 SHALL have port alu_s  output  3  ALU select.
REQ-013 SHALL have ports alu_out, alu_cout  input  1 each  ALU result bit and chain-out.
REQ-014 SHALL have port top  output  WORD  top-of-stack (TOS) value, 0 when empty.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 SHALL have port flag  output  1  final alu_cout of last completed EXEC.
REQ-017 SHALL have ports done, err  output  1 each  one-cycle completion pulse; err qualifies done as rejected.

Function
REQ-018 SHALL implement FSM states IDLE, SHIFT, WB; cmd_ready = (state == IDLE).
REQ-019 PUSH accepted at edge T: if count < DEPTH, entry[count] <= cmd_data, count+1; else no change, err=1; done=1 during cycle T+1.
REQ-020 POP accepted at edge T: if count > 0, count-1; else no change, err=1; done=1 during cycle T+1.
REQ-021 CLEAR accepted at edge T: count <= 0, flag <= 0; done=1 during cycle T+1; never err.
REQ-022 EXEC with count < 2: no state change, remains IDLE, err=1 and done=1 during cycle T+1.
REQ-023 EXEC with count >= 2: latch cmd_op into alu_s and cmd_cin into the chain register; enter SHIFT with bit index i=0.
REQ-024 In SHIFT, bit i: alu_a = TOS[i], alu_b = NOS[i] (entry[count-2]), alu_c = chain register; LSB first.
REQ-025 Each SHIFT cycle, result[i] <= alu_out, chain register <= alu_cout, i+1; after bit WORD-1, go to WB.
REQ-026 SHIFT lasts exactly WORD cycles (T+1 .. T+WORD); WB is cycle T+WORD+1.
REQ-027 In WB: entry[count-2] <= result, count-1, flag <= chain register, done=1, err=0; then IDLE.
REQ-028 Outside SHIFT, alu_a = alu_b = alu_c = 0; alu_s holds the last latched op.
REQ-029 Commands are accepted only in IDLE; cmd_valid in SHIFT/WB is ignored, cmd_kind/cmd_data need not be stable.
REQ-030 Back-to-back PUSH/POP/CLEAR SHALL be accepted every cycle; the done pulses are pipelined one cycle behind acceptance.
REQ-031 top SHALL be combinational from the registered stack: entry[count-1] when count>0, else 0.
REQ-032 The stack contents during SHIFT SHALL remain unchanged; only WB modifies them.
REQ-033 cmd_op is forwarded unmodified; the block SHALL NOT interpret ALU function.

Reset
REQ-034 rst SHALL force state=IDLE, count=0, flag=0, done=0, err=0, alu_s=0, chain=0, i=0; entry contents don't-care.
REQ-035 rst asserted during SHIFT or WB SHALL abort the EXEC with no WB and no done pulse.
REQ-036 rst has priority over any simultaneous command.

Verification (ALU slice attached, s=0: out=a^b, cout=c&(a^b))
REQ-037 PUSH 0011, PUSH 0101, EXEC op0 cin1 -> top=0110, count=1, flag=0, done in WB cycle at T+5.
REQ-038 PUSH 1111, PUSH 0000, EXEC op0 cin1 -> top=1111, flag=1, alu_c high all 4 SHIFT cycles.
REQ-039 DEPTH+1 PUSHes -> final done with err=1, count=DEPTH, top=last accepted value.
REQ-040 POP on empty; EXEC with count=1 -> each done with err=1, count unchanged, no SHIFT cycles.
REQ-041 rst at SHIFT bit 2 -> next cycle IDLE, count=0, flag=0, no done; cmd_ready=1.
REQ-042 cmd_valid held high during SHIFT with PUSH -> ignored; accepted only after WB.
